// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo_pkt: DEPTH x W words, synchronous write, asynchronous read.
module stream_fifo_mem #(
    parameter int AW = 8,
    parameter int W  = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_pkt.sv
// AXI4-stream FWFT FIFO with level/packet counts and optional store-and-forward.
// Build macro STREAM_FIFO_PKT_DROP_EN (PKT_MODE=1 only) drops packets that overflow instead of backpressuring.
module stream_fifo_pkt #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int PKT_MODE = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   level,
    output logic [AW:0]   pkt_count,
    output logic          empty,
    output logic          full,
    output logic [15:0]   drop_cnt
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
`ifdef STREAM_FIFO_PKT_DROP_EN
    localparam bit DROP_EN = (PKT_MODE != 0);
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic [AW-1:0] rd_ptr, wr_ptr, commit_ptr;
    logic [AW:0]   uncommit_cnt, level_nxt, pkt_nxt;
    logic          jumbo, discard;
    logic          wr_fire, rd_fire, overflow;
    logic [DW:0]   rd_word;

    stream_fifo_mem #(.AW(AW), .W(DW+1)) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata ({s_last, s_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign s_ready  = DROP_EN ? 1'b1 : !full;
    assign m_valid  = (PKT_MODE == 0) ? !empty : ((pkt_count != '0 || jumbo) && !empty);
    assign m_data   = rd_word[DW-1:0];
    assign m_last   = m_valid & rd_word[DW];
    assign wr_fire  = s_valid && s_ready && !full && !discard;
    assign rd_fire  = m_valid && m_ready;
    assign overflow = DROP_EN && s_valid && full && !discard;

    // An overflow rewinds the uncommitted beats out of the level as well.
    always_comb begin
        level_nxt = level;
        pkt_nxt   = pkt_count;
        if (overflow) level_nxt = level_nxt - uncommit_cnt;
        if (wr_fire)  level_nxt = level_nxt + ONE;
        if (rd_fire)  level_nxt = level_nxt - ONE;
        if (wr_fire && s_last) pkt_nxt = pkt_nxt + ONE;
        if (rd_fire && m_last) pkt_nxt = pkt_nxt - ONE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            uncommit_cnt <= '0;
            level        <= '0;
            pkt_count    <= '0;
            jumbo        <= 1'b0;
            discard      <= 1'b0;
        end else begin
            level     <= level_nxt;
            pkt_count <= pkt_nxt;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (overflow) begin
                wr_ptr       <= commit_ptr;
                uncommit_cnt <= '0;
                discard      <= !s_last;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (s_last) begin
                        commit_ptr   <= wr_ptr + 1'b1;
                        uncommit_cnt <= '0;
                    end else begin
                        uncommit_cnt <= uncommit_cnt + ONE;
                    end
                end
                if (discard && s_valid && s_last) discard <= 1'b0;
            end
            // A packet larger than the FIFO would never commit; stream it through instead.
            if (!DROP_EN && PKT_MODE != 0 && full && pkt_count == '0)
                jumbo <= 1'b1;
            else if (rd_fire && m_last)
                jumbo <= 1'b0;
        end
    end

`ifdef STREAM_FIFO_PKT_DROP_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            drop_cnt_q <= '0;
        else if (overflow && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_cnt = DROP_EN ? drop_cnt_q : 16'd0;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_stream_fifo_pkt.sv
// Directed bench for stream_fifo_pkt: one cut-through and one packet-mode instance, AW=2, DW=8.
module tb_stream_fifo_pkt;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] s_data;
    logic       s_valid, s_last, m_ready;

    logic       ct_s_ready, ct_m_last, ct_m_valid, ct_empty, ct_full;
    logic [7:0] ct_m_data;
    logic [2:0] ct_level, ct_pkt_count;
    logic [15:0] ct_drop_cnt;

    logic       pk_s_ready, pk_m_last, pk_m_valid, pk_empty, pk_full;
    logic [7:0] pk_m_data;
    logic [2:0] pk_level, pk_pkt_count;
    logic [15:0] pk_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_fifo_pkt #(.AW(2), .DW(8), .PKT_MODE(0)) u_ct (
        .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(ct_s_ready), .m_data(ct_m_data), .m_last(ct_m_last), .m_valid(ct_m_valid),
        .m_ready(m_ready), .level(ct_level), .pkt_count(ct_pkt_count), .empty(ct_empty),
        .full(ct_full), .drop_cnt(ct_drop_cnt)
    );

    stream_fifo_pkt #(.AW(2), .DW(8), .PKT_MODE(1)) u_pk (
        .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(pk_s_ready), .m_data(pk_m_data), .m_last(pk_m_last), .m_valid(pk_m_valid),
        .m_ready(m_ready), .level(pk_level), .pkt_count(pk_pkt_count), .empty(pk_empty),
        .full(pk_full), .drop_cnt(pk_drop_cnt)
    );

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        logic       ml;
        logic [2:0] lvl;
        logic [2:0] pc;
        logic       srdy;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        m_ready = mr;
    endtask

    initial begin
        int n_vec;
        int sent;
        int got;
        logic [2:0] max_lvl;

        // Pre-edge expectations for the packet-mode instance: 3-beat packet, then a full/backpressure run.
        //          sv  sd     sl mr   mv  md     ml lvl pc srdy
        vt[0]  = '{1, 8'hA0, 0, 0,   0, 8'h00, 0, 0, 0, 1};
        vt[1]  = '{1, 8'hA1, 0, 0,   0, 8'h00, 0, 1, 0, 1};
        vt[2]  = '{1, 8'hA2, 1, 0,   0, 8'h00, 0, 2, 0, 1};
        vt[3]  = '{0, 8'h00, 0, 1,   1, 8'hA0, 0, 3, 1, 1};
        vt[4]  = '{0, 8'h00, 0, 1,   1, 8'hA1, 0, 2, 1, 1};
        vt[5]  = '{0, 8'h00, 0, 1,   1, 8'hA2, 1, 1, 1, 1};
        vt[6]  = '{0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 1};
        vt[7]  = '{1, 8'hB0, 0, 0,   0, 8'h00, 0, 0, 0, 1};
        vt[8]  = '{1, 8'hB1, 0, 0,   0, 8'h00, 0, 1, 0, 1};
        vt[9]  = '{1, 8'hB2, 0, 0,   0, 8'h00, 0, 2, 0, 1};
        vt[10] = '{1, 8'hB3, 1, 0,   0, 8'h00, 0, 3, 0, 1};
        vt[11] = '{1, 8'hC0, 1, 0,   1, 8'hB0, 0, 4, 1, 0};
        vt[12] = '{1, 8'hC0, 1, 1,   1, 8'hB0, 0, 4, 1, 0};
        vt[13] = '{1, 8'hC0, 1, 0,   1, 8'hB1, 0, 3, 1, 1};
        vt[14] = '{0, 8'h00, 0, 1,   1, 8'hB1, 0, 4, 2, 0};
        vt[15] = '{0, 8'h00, 0, 1,   1, 8'hB2, 0, 3, 2, 1};
        vt[16] = '{0, 8'h00, 0, 1,   1, 8'hB3, 1, 2, 2, 1};
        vt[17] = '{0, 8'h00, 0, 1,   1, 8'hC0, 1, 1, 1, 1};
        vt[18] = '{0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 1};
`ifdef STREAM_FIFO_PKT_DROP_EN
        n_vec = 7;
`else
        n_vec = 19;
`endif

        do_reset();
        chk("rst_m_valid", {31'd0, pk_m_valid}, 32'd0);
        chk("rst_m_last",  {31'd0, pk_m_last},  32'd0);
        chk("rst_s_ready", {31'd0, pk_s_ready}, 32'd1);
        chk("rst_empty",   {31'd0, pk_empty},   32'd1);
        chk("rst_full",    {31'd0, pk_full},    32'd0);

        for (int i = 0; i < n_vec; i++) begin
            drive(vt[i].sv, vt[i].sd, vt[i].sl, vt[i].mr);
            #1;
            chk($sformatf("vec%0d_m_valid", i), {31'd0, pk_m_valid}, {31'd0, vt[i].mv});
            if (vt[i].mv)
                chk($sformatf("vec%0d_m_data", i), {24'd0, pk_m_data}, {24'd0, vt[i].md});
            chk($sformatf("vec%0d_m_last", i),  {31'd0, pk_m_last},  {31'd0, vt[i].ml});
            chk($sformatf("vec%0d_level", i),   {29'd0, pk_level},   {29'd0, vt[i].lvl});
            chk($sformatf("vec%0d_pkt_count", i), {29'd0, pk_pkt_count}, {29'd0, vt[i].pc});
            chk($sformatf("vec%0d_s_ready", i), {31'd0, pk_s_ready}, {31'd0, vt[i].srdy});
            chk($sformatf("vec%0d_empty", i),   {31'd0, pk_empty},   {31'd0, vt[i].lvl == 3'd0});
            chk($sformatf("vec%0d_full", i),    {31'd0, pk_full},    {31'd0, vt[i].lvl == 3'd4});
            tick();
        end
        drive(0, 8'h00, 0, 0);

        // Cut-through: one-cycle latency, head holds while m_ready=0.
        do_reset();
        drive(1, 8'h11, 0, 0);
        #1;
        chk("ct_pre_m_valid", {31'd0, ct_m_valid}, 32'd0);
        tick();
        chk("ct_lat_m_valid", {31'd0, ct_m_valid}, 32'd1);
        chk("ct_lat_m_data",  {24'd0, ct_m_data},  32'h11);
        chk("ct_lat_level",   {29'd0, ct_level},   32'd1);
        drive(1, 8'h22, 1, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        chk("ct_level2",     {29'd0, ct_level},     32'd2);
        chk("ct_pkt_count1", {29'd0, ct_pkt_count}, 32'd1);
        chk("ct_head_last",  {31'd0, ct_m_last},    32'd0);
        chk("ct_head_data",  {24'd0, ct_m_data},    32'h11);
        chk("ct_drop_cnt",   {16'd0, ct_drop_cnt},  32'd0);

`ifndef STREAM_FIFO_PKT_DROP_EN
        // Oversize packet in packet mode must stream through once the FIFO fills.
        do_reset();
        sent = 0;
        got = 0;
        max_lvl = 3'd0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (sent < 6) drive(1, 8'hD0 + 8'(sent), sent == 5, 1);
            else          drive(0, 8'h00, 0, 1);
            #1;
            if (pk_level > max_lvl) max_lvl = pk_level;
            if (pk_m_valid) begin
                chk($sformatf("jumbo_data%0d", got), {24'd0, pk_m_data}, {24'd0, 8'hD0 + 8'(got)});
                chk($sformatf("jumbo_last%0d", got), {31'd0, pk_m_last}, {31'd0, got == 5});
                got++;
            end
            if (s_valid && pk_s_ready) sent++;
            tick();
        end
        drive(0, 8'h00, 0, 0);
        chk("jumbo_beats",     got,                      32'd6);
        chk("jumbo_max_level", {29'd0, max_lvl},         32'd4);
        chk("jumbo_pkt_count", {29'd0, pk_pkt_count},    32'd0);
        chk("jumbo_level",     {29'd0, pk_level},        32'd0);
        chk("jumbo_m_valid",   {31'd0, pk_m_valid},      32'd0);
        chk("drop_cnt_tied",   {16'd0, pk_drop_cnt},     32'd0);
`else
        // Overflowing packet is discarded while the earlier committed one survives.
        do_reset();
        drive(1, 8'hE0, 0, 0); tick();
        drive(1, 8'hE1, 1, 0); tick();
        for (int b = 0; b < 5; b++) begin
            drive(1, 8'hF0 + 8'(b), b == 4, 0);
            tick();
        end
        drive(0, 8'h00, 0, 0);
        chk("drop_cnt",       {16'd0, pk_drop_cnt},  32'd1);
        chk("drop_level",     {29'd0, pk_level},     32'd2);
        chk("drop_pkt_count", {29'd0, pk_pkt_count}, 32'd1);
        drive(0, 8'h00, 0, 1);
        #1;
        chk("drop_head0", {24'd0, pk_m_data}, 32'hE0);
        tick();
        chk("drop_head1", {24'd0, pk_m_data}, 32'hE1);
        chk("drop_last1", {31'd0, pk_m_last}, 32'd1);
        tick();
        drive(0, 8'h00, 0, 0);
        chk("drop_level_end", {29'd0, pk_level}, 32'd0);
        chk("drop_m_valid",   {31'd0, pk_m_valid}, 32'd0);
`endif

        // Reset mid-packet discards the partial packet.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            drive(1, 8'h50 + 8'(b), 0, 0);
            tick();
        end
        chk("midrst_pre_level", {29'd0, pk_level}, 32'd3);
        resetn = 1'b0;
        drive(1, 8'h53, 0, 0);
        tick();
        resetn = 1'b1;
        drive(0, 8'h00, 0, 0);
        chk("midrst_level",     {29'd0, pk_level},     32'd0);
        chk("midrst_m_valid",   {31'd0, pk_m_valid},   32'd0);
        chk("midrst_m_last",    {31'd0, pk_m_last},    32'd0);
        chk("midrst_s_ready",   {31'd0, pk_s_ready},   32'd1);
        chk("midrst_pkt_count", {29'd0, pk_pkt_count}, 32'd0);
        chk("midrst_empty",     {31'd0, pk_empty},     32'd1);
        chk("midrst_ct_level",  {29'd0, ct_level},     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo_pkt.md
Name: stream_fifo_pkt

Overview:
- Parametrised AXI4-stream FIFO, successor to the single-mode stream FIFO.
- Adds true backpressure, fill level and packet count outputs.
- Adds a store-and-forward packet mode that releases a packet only once its last beat is stored.
- Sits between soc stream producers (UART/Ethernet-style peripherals, picorv32 bus bridges) and consumers that need whole packets.

Parameters:
- AW, 8, address width; depth = 2**AW entries.
- DW, 8, data width; storage word width = DW+1 (data plus last).
- PKT_MODE, 1, 1 = store-and-forward, 0 = cut-through (plain FWFT FIFO).

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- s_data  in  DW  input beat data
- s_valid  in  1  input beat valid
- s_last  in  1  input beat ends packet
- s_ready  out  1  FIFO accepts beat
- m_data  out  DW  output beat data
- m_last  out  1  output beat ends packet; 0 whenever m_valid=0
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer accepts beat
- level  out  AW+1  entries stored, including uncommitted beats
- pkt_count  out  AW+1  complete packets stored
- empty  out  1  level==0
- full  out  1  level==2**AW
- drop_cnt  out  16  dropped packets, saturating; constant 0 without STREAM_FIFO_PKT_DROP_EN

Behaviour:
- Reset (resetn=0 at an edge): rd_ptr, wr_ptr, level, pkt_count, drop_cnt, jumbo and discard flags all cleared. Outputs after reset: m_valid=0, m_last=0, s_ready=1, empty=1, full=0. A partially stored packet is lost. Memory contents are not cleared.
- Write fires on s_valid&s_ready. Read fires on m_valid&m_ready.
- s_ready = !full (drop variant: see Optional Feature).
- Storage read is asynchronous at rd_ptr; m_data/m_last are visible in the same cycle m_valid rises.
- Latency, cut-through: a beat accepted at edge N gives m_valid=1 after edge N.
- Latency, packet mode: m_valid rises after the edge accepting the last beat.
- Pointers are AW bits and wrap modulo 2**AW. level tracks writes minus reads; a simultaneous write and read leaves it unchanged.
- pkt_count: +1 on an accepted s_last beat, -1 on a read m_last beat; both in one cycle leaves it unchanged.
- m_valid, PKT_MODE=0: level!=0.
- m_valid, PKT_MODE=1: (pkt_count!=0 || jumbo) && level!=0.
- Jumbo (oversize packet, drop disabled):
  - Set when full && pkt_count==0.
  - While set, the packet streams cut-through.
  - Cleared when its m_last beat is read.
  - Prevents deadlock.
- Full with read and write offered in the same cycle: s_ready is already 0, so no write; the read proceeds.
- Empty with a write: no read that cycle, because m_valid=0.
- m_data is don't-care when m_valid=0. m_valid holds until accepted; m_data/m_last are stable while m_valid&!m_ready.

Optional Feature:
- Macro: STREAM_FIFO_PKT_DROP_EN; effective only with PKT_MODE=1.
- Enabled:
  - s_ready = 1 always; jumbo logic removed.
  - FIFO keeps commit_ptr = wr_ptr at the last completed packet boundary.
  - A beat arriving while full: wr_ptr rewinds to commit_ptr, level drops by the uncommitted count, and the discard flag is set.
  - Beats are discarded through the next s_last, which clears the flag.
  - drop_cnt increments once per dropped packet, saturating at 0xFFFF.
- Disabled: behaviour as above; drop_cnt tied 0.

Decomposition:
- No shared package; localparam DEPTH=2**AW is local.
- One sub-module, stream_fifo_mem: DEPTH x (DW+1) storage with synchronous write and asynchronous read.
- Pointer, count, jumbo and discard logic stays in stream_fifo_pkt.

Test Plan:
- AW=2, PKT_MODE=0: write 0x11,0x22 (last on 0x22) with m_ready=0 -> m_valid=1 one cycle after the first write; level=2, pkt_count=1, m_last=0 at head.
- AW=2, PKT_MODE=1: write 3 beats, last on the third -> m_valid=0 until the edge accepting beat 3, then 0xA0..0xA2 out in order, m_last only on 0xA2.
- AW=2, fill 4 beats then hold s_valid -> full=1, s_ready=0. Pulse m_ready for one cycle -> exactly one beat out, level 4->3, the next write accepted the following edge.
- AW=2, PKT_MODE=1, 6-beat packet, no drop -> jumbo releases at full; all 6 beats delivered in order; pkt_count ends 0.
- With STREAM_FIFO_PKT_DROP_EN: a 2-beat packet stored, then a 5-beat packet -> the 2-beat packet is delivered, the 5-beat packet is discarded, drop_cnt=1, level=0 afterwards.
- resetn=0 for one cycle mid-packet with level=3 -> next cycle level=0, m_valid=0, s_ready=1, pkt_count=0.
